// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock, start/busy/done handshake
// Optional feature: define SIGNED_DIV_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_r_q, res_r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   partial;
    logic             take;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] fin_q, fin_r;

    // Dividend register doubles as the quotient shift register: MSBs leave as quotient bits enter.
    assign partial  = {rem_q, dvd_q[WIDTH-1]};
    assign take     = (partial >= {1'b0, dsr_q});
    assign step_rem = take ? (partial[WIDTH-1:0] - dsr_q) : partial[WIDTH-1:0];
    assign step_dvd = {dvd_q[WIDTH-2:0], take};

`ifdef SIGNED_DIV_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign fin_q = neg_quo_q ? (~step_dvd + 1'b1) : step_dvd;
    assign fin_r = neg_rem_q ? (~step_rem + 1'b1) : step_rem;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == S_IDLE && start && divisor != '0) begin
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign fin_q = step_dvd;
    assign fin_r = step_rem;
`endif

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        res_r_d = res_r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quo_d   = '1;
                        res_r_d = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dsr_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                dvd_d = step_dvd;
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    quo_d   = fin_q;
                    res_r_d = fin_r;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            res_r_q <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            res_r_q <= res_r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = res_r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;
    localparam int W  = 16;
    localparam int CW = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        z = (b == '0);
        if (b == '0) begin
            q = '1;
            r = a;
        end
`ifdef SIGNED_DIV_EN
        else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else begin
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit stray);
        logic [W-1:0] eq, er, prev_q;
        logic         ez;
        int           k, exp_k;
        ref_div(a, b, eq, er, ez);
        prev_q   = quotient;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        exp_k = (b == '0) ? 0 : W;
        k = 0;
        while (!done && k < W + 4) begin
            check("busy_run", busy, 1);
            if (k == W / 2) begin
                check("q_hold_run", quotient, prev_q);
                check("dbz_clear_run", div_by_zero, 0);
            end
            if (stray && k == 3) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            tick();
            start = 1'b0;
            k++;
        end
        check("done_latency", k, exp_k);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
`ifndef SIGNED_DIV_EN
        if (b != '0) begin
            check("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        end
`endif
        tick();
        check("done_drop", done, 0);
        check("busy_drop", busy, 0);
        check("quotient_held", quotient, eq);
        check("remainder_held", remainder, er);
        check("dbz_held", div_by_zero, ez);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         ez;
        bit           saw_done;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_div(16'd100, 16'd7, 1'b0);
        check("q_100_7", quotient, 16'd14);
        check("r_100_7", remainder, 16'd2);

        run_div(16'd1234, 16'd0, 1'b0);
        check("q_div0", quotient, 16'hFFFF);
        check("r_div0", remainder, 16'd1234);
        check("dbz_div0", div_by_zero, 1);

        run_div(16'd100, 16'd7, 1'b1);
        run_div(16'hFFFF, 16'd1, 1'b0);
        run_div(16'd5, 16'd9, 1'b0);

        // start held high: second division accepted two edges after done
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        dividend = 16'd50;
        divisor  = 16'd5;
        repeat (W) tick();
        check("held_done1", done, 1);
        check("held_q1", quotient, 16'd14);
        check("held_r1", remainder, 16'd2);
        tick();
        check("held_idle_busy", busy, 0);
        tick();
        check("held_accept_busy", busy, 1);
        start = 1'b0;
        repeat (W) tick();
        ref_div(16'd50, 16'd5, eq, er, ez);
        check("held_done2", done, 1);
        check("held_q2", quotient, eq);
        check("held_r2", remainder, er);
        tick();

        // reset mid-operation aborts with no done pulse
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (W + 4) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        run_div(16'd9, 16'd3, 1'b0);

`ifdef SIGNED_DIV_EN
        run_div(16'hFFF9, 16'd2, 1'b0);
        check("s_q_m7_2", quotient, 16'hFFFD);
        check("s_r_m7_2", remainder, 16'hFFFF);
        run_div(16'd7, 16'hFFFE, 1'b0);
        check("s_q_7_m2", quotient, 16'hFFFD);
        check("s_r_7_m2", remainder, 16'd1);
        run_div(16'h8000, 16'hFFFF, 1'b0);
        check("s_q_ovf", quotient, 16'h8000);
        check("s_r_ovf", remainder, 16'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = '1;
                1:       a = W'($urandom_range(0, 20));
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = (a == '1) ? a : a + W'($urandom_range(1, 50));
                3:       b = '1;
                default: b = W'($urandom);
            endcase
            run_div(a, b, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
